// File: rtl/switch_event_detector_pkg.sv
// Shared definitions for the switch event detector: FSM state encoding and
// mailbox event codes.
package switch_event_detector_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned EVT_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_LONG  = 2'd2
   } state_e;

   localparam logic [EVT_W-1:0] EVT_SHORT    = 2'b00;
   localparam logic [EVT_W-1:0] EVT_LONG     = 2'b01;
   localparam logic [EVT_W-1:0] EVT_REPEAT   = 2'b10;
   localparam logic [EVT_W-1:0] EVT_LONG_REL = 2'b11;

endpackage

// File: rtl/evt_mailbox.sv
// Single-entry event mailbox: holds one pending event code until acknowledged,
// flags (sticky) any event that arrives while it is still full.
module evt_mailbox
   import switch_event_detector_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             post_i,
   input  logic [EVT_W-1:0] code_i,
   input  logic             ack_i,
   output logic             valid_o,
   output logic [EVT_W-1:0] code_o,
   output logic             overflow_o
);

   logic             valid_q, valid_d;
   logic [EVT_W-1:0] code_q, code_d;
   logic             ovf_q, ovf_d;

   // An ack frees the slot in the same cycle, so a coincident post is accepted.
   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      ovf_d   = ovf_q;
      if (ack_i && valid_q) begin
         ovf_d   = 1'b0;
         valid_d = post_i;
         if (post_i) begin
            code_d = code_i;
         end
      end else if (post_i) begin
         if (!valid_q) begin
            valid_d = 1'b1;
            code_d  = code_i;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         code_q  <= EVT_SHORT;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         code_q  <= code_d;
         ovf_q   <= ovf_d;
      end
   end

   assign valid_o    = valid_q;
   assign code_o     = code_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/switch_event_detector.sv
// Turns a debounced switch level into press/release/long/repeat strobes and
// posts click-level events into a one-deep mailbox for a slow consumer.
module switch_event_detector
   import switch_event_detector_pkg::*;
#(
   parameter int unsigned IS_PULLUP     = 0,
   parameter int unsigned LONG_CYCLES   = 1000,
   parameter int unsigned REPEAT_CYCLES = 250,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_debounced,
   input  logic       i_evt_ack,
   output logic       o_pressed,
   output logic       o_press,
   output logic       o_release,
   output logic       o_long,
   output logic       o_repeat,
   output logic       o_evt_valid,
   output logic [1:0] o_evt_code,
   output logic       o_evt_overflow
);

   localparam logic             ACT_POL = (IS_PULLUP != 0);
   localparam logic             REP_EN  = (REPEAT_CYCLES != 0);
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] REP_TC  =
      CNT_W'((REPEAT_CYCLES == 0) ? 32'd0 : REPEAT_CYCLES - 32'd1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed_q;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             active_c;
   logic             post_c;
   logic [EVT_W-1:0] post_code_c;

   assign active_c = i_debounced ^ ACT_POL;

   // Release is tested first so it always wins over a same-cycle terminal count.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;
      post_c      = 1'b0;
      post_code_c = EVT_SHORT;
      unique case (state_q)
         ST_IDLE: begin
            if (active_c) begin
               state_d = ST_PRESS;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         ST_PRESS: begin
            if (!active_c) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               release_d   = 1'b1;
               post_c      = 1'b1;
               post_code_c = EVT_SHORT;
            end else if (cnt_q == LONG_TC) begin
               state_d     = ST_LONG;
               cnt_d       = '0;
               long_d      = 1'b1;
               post_c      = 1'b1;
               post_code_c = EVT_LONG;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LONG: begin
            if (!active_c) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               release_d   = 1'b1;
               post_c      = 1'b1;
               post_code_c = EVT_LONG_REL;
            end else if (!REP_EN) begin
               cnt_d = '0;
            end else if (cnt_q == REP_TC) begin
               cnt_d       = '0;
               repeat_d    = 1'b1;
               post_c      = 1'b1;
               post_code_c = EVT_REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pressed_q <= active_c;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   evt_mailbox u_mailbox (
      .clk       (clk),
      .rst_n     (rst_n),
      .post_i    (post_c),
      .code_i    (post_code_c),
      .ack_i     (i_evt_ack),
      .valid_o   (o_evt_valid),
      .code_o    (o_evt_code),
      .overflow_o(o_evt_overflow)
   );

   assign o_pressed = pressed_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;
   assign o_repeat  = repeat_q;

endmodule

// File: tb/tb_switch_event_detector.sv
// Bench for switch_event_detector: two parameterisations driven side by side,
// checked every cycle against a hold-length based event model.
module tb_switch_event_detector;

   localparam int A_LONG = 8;
   localparam int A_REP  = 4;
   localparam int B_LONG = 5;
   localparam int B_REP  = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic act_r = 1'b0;
   logic ack_r = 1'b0;
   logic a_db, b_db;

   logic a_pressed, a_press, a_rel, a_long, a_rep, a_valid, a_ovf;
   logic [1:0] a_code;
   logic b_pressed, b_press, b_rel, b_long, b_rep, b_valid, b_ovf;
   logic [1:0] b_code;

   int checks = 0;
   int fails  = 0;
   int passes = 0;

   always #5 clk = ~clk;

   assign a_db = act_r;
   assign b_db = ~act_r;

   switch_event_detector #(
      .IS_PULLUP(0), .LONG_CYCLES(A_LONG), .REPEAT_CYCLES(A_REP), .CNT_W(8)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .i_debounced(a_db), .i_evt_ack(ack_r),
      .o_pressed(a_pressed), .o_press(a_press), .o_release(a_rel),
      .o_long(a_long), .o_repeat(a_rep), .o_evt_valid(a_valid),
      .o_evt_code(a_code), .o_evt_overflow(a_ovf)
   );

   switch_event_detector #(
      .IS_PULLUP(1), .LONG_CYCLES(B_LONG), .REPEAT_CYCLES(B_REP), .CNT_W(4)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .i_debounced(b_db), .i_evt_ack(ack_r),
      .o_pressed(b_pressed), .o_press(b_press), .o_release(b_rel),
      .o_long(b_long), .o_repeat(b_rep), .o_evt_valid(b_valid),
      .o_evt_code(b_code), .o_evt_overflow(b_ovf)
   );

   // n = number of consecutive pressed samples so far (0 when released).
   typedef struct {
      int       n;
      bit       pressed, press, rel, lng, rep, valid, ovf;
      bit [1:0] code;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t zero_mdl();
      mdl_t z;
      z.n = 0; z.pressed = 0; z.press = 0; z.rel = 0; z.lng = 0;
      z.rep = 0; z.valid = 0; z.ovf = 0; z.code = 2'b00;
      return z;
   endfunction

   // Long fires on pressed sample LONG+1; repeats every REP samples after that.
   function automatic mdl_t step(mdl_t s, bit act, bit ack, int lc, int rc);
      mdl_t r;
      bit post;
      bit [1:0] pc;
      r = s;
      r.press = 0; r.rel = 0; r.lng = 0; r.rep = 0;
      r.pressed = act;
      post = 0;
      pc = 2'b00;
      if (act) begin
         r.n = s.n + 1;
         if (s.n == 0) r.press = 1;
         else if (r.n == lc + 1) begin r.lng = 1; post = 1; pc = 2'b01; end
         else if (rc > 0 && r.n > lc + 1 && ((r.n - lc - 1) % rc) == 0) begin
            r.rep = 1; post = 1; pc = 2'b10;
         end
      end else begin
         if (s.n > 0) begin
            r.rel = 1; post = 1;
            pc = (s.n >= lc + 1) ? 2'b11 : 2'b00;
         end
         r.n = 0;
      end
      if (ack && s.valid) begin
         r.ovf = 0;
         r.valid = post;
         if (post) r.code = pc;
      end else if (post) begin
         if (!s.valid) begin r.valid = 1; r.code = pc; end
         else r.ovf = 1;
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [1:0] got, logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end else begin
         passes++;
      end
   endtask

   task automatic compare_all();
      chk("a_pressed", {1'b0, a_pressed}, {1'b0, ma.pressed});
      chk("a_press",   {1'b0, a_press},   {1'b0, ma.press});
      chk("a_release", {1'b0, a_rel},     {1'b0, ma.rel});
      chk("a_long",    {1'b0, a_long},    {1'b0, ma.lng});
      chk("a_repeat",  {1'b0, a_rep},     {1'b0, ma.rep});
      chk("a_valid",   {1'b0, a_valid},   {1'b0, ma.valid});
      chk("a_code",    a_code,            ma.code);
      chk("a_ovf",     {1'b0, a_ovf},     {1'b0, ma.ovf});
      chk("b_pressed", {1'b0, b_pressed}, {1'b0, mb.pressed});
      chk("b_press",   {1'b0, b_press},   {1'b0, mb.press});
      chk("b_release", {1'b0, b_rel},     {1'b0, mb.rel});
      chk("b_long",    {1'b0, b_long},    {1'b0, mb.lng});
      chk("b_repeat",  {1'b0, b_rep},     {1'b0, mb.rep});
      chk("b_valid",   {1'b0, b_valid},   {1'b0, mb.valid});
      chk("b_code",    b_code,            mb.code);
      chk("b_ovf",     {1'b0, b_ovf},     {1'b0, mb.ovf});
   endtask

   // Compare the previous edge's outputs, then drive and predict the next edge.
   task automatic tick(bit rst, bit act, bit ack);
      @(negedge clk);
      compare_all();
      rst_n = rst;
      act_r = act;
      ack_r = ack;
      if (!rst) begin
         ma = zero_mdl();
         mb = zero_mdl();
      end else begin
         ma = step(ma, act, ack, A_LONG, A_REP);
         mb = step(mb, act, ack, B_LONG, B_REP);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p_idx, l_idx, r_idx, nrep, first_rep, nlong, left;
      bit act;
      ma = zero_mdl();
      mb = zero_mdl();

      // Reset, then idle with the switch released on both instances.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
      chk("lit_reset_a_valid", {1'b0, a_valid}, 2'd0);
      chk("lit_reset_a_code", a_code, 2'b00);
      chk("lit_pullup_idle_b_pressed", {1'b0, b_pressed}, 2'd0);
      chk("lit_pullup_idle_b_valid", {1'b0, b_valid}, 2'd0);

      // Short 5-cycle press without ack.
      nlong = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, i < 5, 1'b0);
         nlong += int'(a_long);
         if (i == 1) begin
            chk("lit_short_a_press", {1'b0, a_press}, 2'd1);
            chk("lit_pullup_b_pressed", {1'b0, b_pressed}, 2'd1);
            chk("lit_pullup_b_press", {1'b0, b_press}, 2'd1);
         end
         if (i == 6) begin
            chk("lit_short_a_release", {1'b0, a_rel}, 2'd1);
            chk("lit_short_a_valid", {1'b0, a_valid}, 2'd1);
            chk("lit_short_a_code", a_code, 2'b00);
         end
      end
      chk("lit_short_no_long", 2'(nlong), 2'd0);

      // 20-cycle press with ack held high: long then repeats, release code 11.
      p_idx = -1; l_idx = -1; r_idx = -1; nrep = 0; first_rep = -1;
      for (int i = 0; i < 22; i++) begin
         tick(1'b1, i < 20, 1'b1);
         if (a_press) p_idx = i;
         if (a_long) l_idx = i;
         if (a_rep) begin
            nrep++;
            if (first_rep < 0) first_rep = i;
         end
         if (a_rel) begin
            r_idx = i;
            chk("lit_long_rel_code", a_code, 2'b11);
            chk("lit_long_rel_valid", {1'b0, a_valid}, 2'd1);
         end
      end
      chk("lit_long_after_press", 2'(l_idx - p_idx), 2'(A_LONG));
      chk("lit_first_repeat_gap", 2'(first_rep - l_idx), 2'(A_REP));
      chk("lit_repeat_count", 2'(nrep), 2'd2);
      chk("lit_release_seen", {1'b0, r_idx == 21}, 2'd1);

      // Two short clicks without ack: first code kept, overflow set; ack clears.
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) tick(1'b1, (i < 3) || (i >= 5 && i < 8), 1'b0);
      chk("lit_ovf_code", a_code, 2'b00);
      chk("lit_ovf_valid", {1'b0, a_valid}, 2'd1);
      chk("lit_ovf_flag", {1'b0, a_ovf}, 2'd1);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      chk("lit_ack_clears_valid", {1'b0, a_valid}, 2'd0);
      chk("lit_ack_clears_ovf", {1'b0, a_ovf}, 2'd0);

      // Ack coincident with a post: new code loaded, no overflow.
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      chk("lit_ack_post_valid", {1'b0, a_valid}, 2'd1);
      chk("lit_ack_post_code", a_code, 2'b11);
      chk("lit_ack_post_ovf", {1'b0, a_ovf}, 2'd0);

      // Release exactly on the long terminal-count cycle: release only.
      tick(1'b1, 1'b0, 1'b1);
      nlong = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b1, 1'b0);
         nlong += int'(a_long);
      end
      tick(1'b1, 1'b0, 1'b0);
      nlong += int'(a_long);
      tick(1'b1, 1'b0, 1'b0);
      nlong += int'(a_long);
      chk("lit_tc_release", {1'b0, a_rel}, 2'd1);
      chk("lit_tc_code", a_code, 2'b00);
      chk("lit_tc_no_long", 2'(nlong), 2'd0);

      // Asynchronous reset while in LONG, switch kept pressed.
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_async_rst_outputs",
          {1'b0, |{a_pressed, a_press, a_rel, a_long, a_rep, a_valid, a_ovf, a_code}},
          2'd0);
      ma = zero_mdl();
      mb = zero_mdl();
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      chk("lit_post_rst_press", {1'b0, a_press}, 2'd1);
      chk("lit_post_rst_no_release", {1'b0, a_rel}, 2'd0);

      // Randomised press/release phases, random acks and rare resets.
      act = 1'b1;
      left = 0;
      for (int k = 0; k < 1500; k++) begin
         if (left == 0) begin
            act = ~act;
            left = act ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 5));
         end
         left--;
         tick($urandom_range(0, 299) != 0, act, $urandom_range(0, 2) == 0);
      end
      tick(1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
